lcd_byte_writer: RTL and testbench



---
 rtl/lcd_byte_writer.sv | 167 ++++++++++++++++
 tb/tb_lcd_byte_writer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: sends one byte to an HD44780-style LCD over its 4-bit bus.
// The high nibble goes first, then the low nibble, each with its own E strobe.
// The block enforces setup, pulse, hold, inter-nibble gap and execution wait.
// Optional macro LCD_LONG_CMD_EN: clear/home commands (rs=0, byte 0x01..0x03)
// use the longer T_LONG execution wait instead of T_EXEC.
module lcd_byte_writer #(
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 12,
   parameter int T_HOLD  = 1,
   parameter int T_GAP   = 50,
   parameter int T_EXEC  = 2000,
   parameter int T_LONG  = 82000,
   parameter int CW      = 18
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_valid,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic       done,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [3:0] lcd_d
);

   // Terminal counts: each state ends on the cycle its counter reaches T-1.
   localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] PULSE_LAST = CW'(T_PULSE - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(T_HOLD - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(T_GAP - 1);
   localparam logic [CW-1:0] EXEC_LAST  = CW'(T_EXEC - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SETUP_H,
      S_PULSE_H,
      S_HOLD_H,
      S_GAP,
      S_SETUP_L,
      S_PULSE_L,
      S_HOLD_L,
      S_WAIT
   } state_t;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [7:0]    byte_reg;
   logic [CW-1:0] wait_last;

`ifdef LCD_LONG_CMD_EN
   localparam logic [CW-1:0] LONG_LAST = CW'(T_LONG - 1);
   // Clear and return-home commands need the long execution wait.
   assign wait_last = (!lcd_rs && (byte_reg == 8'h01 || byte_reg == 8'h02 ||
                                   byte_reg == 8'h03)) ? LONG_LAST : EXEC_LAST;
`else
   assign wait_last = EXEC_LAST;
`endif

   assign wr_ready = (state_reg == S_IDLE);
   assign lcd_rw   = 1'b0;

   // Sequencer: every state clears the counter on entry and leaves at its terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         byte_reg  <= 8'h00;
         lcd_e     <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_d     <= 4'h0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (wr_valid) begin
                  state_reg <= S_SETUP_H;
                  cnt_reg   <= '0;
                  byte_reg  <= wr_data;
                  lcd_rs    <= wr_rs;
                  lcd_d     <= wr_data[7:4];
               end
            end
            S_SETUP_H: begin
               if (cnt_reg == SETUP_LAST) begin
                  state_reg <= S_PULSE_H;
                  cnt_reg   <= '0;
                  lcd_e     <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_PULSE_H: begin
               if (cnt_reg == PULSE_LAST) begin
                  state_reg <= S_HOLD_H;
                  cnt_reg   <= '0;
                  lcd_e     <= 1'b0;
                  // Keep the high nibble driven through the hold window.
                  lcd_d     <= byte_reg[7:4];
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_HOLD_H: begin
               if (cnt_reg == HOLD_LAST) begin
                  state_reg <= S_GAP;
                  cnt_reg   <= '0;
                  lcd_d     <= byte_reg[3:0];
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_GAP: begin
               if (cnt_reg == GAP_LAST) begin
                  state_reg <= S_SETUP_L;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_SETUP_L: begin
               if (cnt_reg == SETUP_LAST) begin
                  state_reg <= S_PULSE_L;
                  cnt_reg   <= '0;
                  lcd_e     <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_PULSE_L: begin
               if (cnt_reg == PULSE_LAST) begin
                  state_reg <= S_HOLD_L;
                  cnt_reg   <= '0;
                  lcd_e     <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_HOLD_L: begin
               if (cnt_reg == HOLD_LAST) begin
                  state_reg <= S_WAIT;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_WAIT: begin
               if (cnt_reg == wait_last) begin
                  state_reg <= S_IDLE;
                  cnt_reg   <= '0;
                  done      <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= S_IDLE;
               cnt_reg   <= '0;
               lcd_e     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: a timeline model predicts every output on every
// cycle from the time of acceptance, and directed plus random bytes exercise it.
module tb_lcd_byte_writer;

   localparam int TS = 2;
   localparam int TP = 12;
   localparam int TH = 1;
   localparam int TG = 50;
   localparam int TE = 2000;
   localparam int TL = 82000;
   localparam int LEN    = 2 * (TS + TP + TH) + TG;  // bus activity per byte
   localparam int HI_END = TS + TP + TH;              // low nibble appears here
   localparam int P2     = HI_END + TG + TS;          // second E rise
   localparam int BUDGET = 90000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready, done, lcd_e, lcd_rs, lcd_rw;
   logic [3:0] lcd_d;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int n_rise = 0;

   lcd_byte_writer #(
      .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG),
      .T_EXEC(TE), .T_LONG(TL), .CW(18)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_rs(wr_rs),
      .wr_data(wr_data), .wr_ready(wr_ready), .done(done), .lcd_e(lcd_e),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Cycles from acceptance to done, straight from the timing rules.
   function automatic int occ_for(input logic rs, input logic [7:0] d);
`ifdef LCD_LONG_CMD_EN
      if (!rs && d >= 8'h01 && d <= 8'h03) return LEN + TL;
`endif
      return LEN + TE;
   endfunction

   // Reference model: remembers the last accepted byte and how long ago it was taken.
   bit         m_active = 1'b0;
   int         m_k = 0;
   int         m_occ = 0;
   int         m_accepts = 0;
   logic [7:0] m_byte = 8'h00;
   logic       m_rs = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_k      <= 0;
         m_occ    <= 0;
         m_byte   <= 8'h00;
         m_rs     <= 1'b0;
      end else if ((!m_active || m_k >= m_occ) && wr_valid) begin
         m_active  <= 1'b1;
         m_k       <= 0;
         m_occ     <= occ_for(wr_rs, wr_data);
         m_byte    <= wr_data;
         m_rs      <= wr_rs;
         m_accepts <= m_accepts + 1;
      end else if (m_active) begin
         m_k <= m_k + 1;
      end
   end

   // Per-cycle comparison of all outputs against the model, plus bus protocol checks.
   logic [8:0] exp_v, got_v;
   logic       x_e;
   logic [3:0] x_d;
   logic       prev_e = 1'b0;
   logic [4:0] prev_bus = 5'h0;

   always @(negedge clk) begin
      if (!m_active) begin
         exp_v = {1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
      end else begin
         x_e = (m_k >= TS && m_k < TS + TP) || (m_k >= P2 && m_k < P2 + TP);
         x_d = (m_k < HI_END) ? m_byte[7:4] : m_byte[3:0];
         exp_v = {x_e, m_rs, x_d, (m_k == m_occ), (m_k >= m_occ), 1'b0};
      end
      got_v = {lcd_e, lcd_rs, lcd_d, done, wr_ready, lcd_rw};
      chk("outputs", {23'h0, got_v}, {23'h0, exp_v});
      if (prev_e && lcd_e) chk("bus_stable_e_high", {27'h0, lcd_rs, lcd_d}, {27'h0, prev_bus});
      if (lcd_e && !prev_e) n_rise++;
      prev_e   = lcd_e;
      prev_bus = {lcd_rs, lcd_d};
   end

   // Present a byte until the model says it was taken; optionally scramble inputs afterwards.
   task automatic send(input logic rs, input logic [7:0] d, input bit keep, input bit mess);
      int start;
      int n;
      start = m_accepts;
      n = 0;
      wr_rs = rs;
      wr_data = d;
      wr_valid = 1'b1;
      while (m_accepts == start && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      acc_cyc = cyc;
      if (!keep) wr_valid = 1'b0;
      if (mess) begin
         wr_data = 8'hFF;
         wr_rs = ~rs;
      end
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (done !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk(tag, cyc - acc_cyc, exp_lat);
      $display("byte done: %s latency %0d cycles", tag, cyc - acc_cyc);
   endtask

   initial begin
      logic       r_rs;
      logic [7:0] r_d;
      int first;
      int start;
      int base;
      int n;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", {23'h0, lcd_e, lcd_rs, lcd_d, done, wr_ready, lcd_rw}, 32'h002);
      rst_n = 1'b1;
      @(negedge clk);

      // Single data byte 'A'.
      send(1'b1, 8'h41, 1'b0, 1'b0);
      wait_done("data_0x41", LEN + TE);

      // Input changes after acceptance must not leak onto the bus; busy request ignored.
      @(negedge clk);
      send(1'b1, 8'h5A, 1'b0, 1'b1);
      repeat (30) @(negedge clk);
      wr_valid = 1'b1;
      wr_data = 8'hC3;
      @(negedge clk);
      wr_valid = 1'b0;
      wait_done("stable_0x5a", LEN + TE);

      // Back-to-back: the second byte is taken on the done cycle.
      @(negedge clk);
      base = n_rise;
      send(1'b1, 8'h48, 1'b1, 1'b0);
      first = acc_cyc;
      wr_data = 8'h49;
      start = m_accepts;
      n = 0;
      while (m_accepts == start && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      acc_cyc = cyc;
      wr_valid = 1'b0;
      chk("b2b_spacing", cyc - first, LEN + TE + 1);
      wait_done("b2b_0x49", LEN + TE);
      chk("b2b_pulses", n_rise - base, 4);

      // Commands: clear (long wait only with the feature) and function set.
      @(negedge clk);
      send(1'b0, 8'h01, 1'b0, 1'b0);
      wait_done("cmd_0x01", occ_for(1'b0, 8'h01));
      @(negedge clk);
      send(1'b0, 8'h28, 1'b0, 1'b0);
      wait_done("cmd_0x28", LEN + TE);

      // Asynchronous reset in the middle of the first E pulse.
      @(negedge clk);
      send(1'b1, 8'h77, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      chk("pre_reset_e", {31'h0, lcd_e}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_e_drop", {31'h0, lcd_e}, 32'h0);
      chk("async_reset_vec", {23'h0, lcd_e, lcd_rs, lcd_d, done, wr_ready, lcd_rw}, 32'h002);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(1'b1, 8'h3C, 1'b0, 1'b0);
      wait_done("after_reset_0x3c", LEN + TE);

      // Random bytes.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         r_rs = 1'($urandom_range(0, 1));
         r_d = 8'($urandom_range(0, 255));
         send(r_rs, r_d, 1'b0, 1'b1);
         wait_done("random", occ_for(r_rs, r_d));
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
